decode_stage: RTL and testbench

//  Registered, flow-controlled instruction-decode pipeline stage for the pipelined RV32I core; sits between fetch and execute.

---
 rtl/decode_stage_pkg.sv | 26 ++
 rtl/decode_stage_if.sv | 15 +
 rtl/decode_fields.sv | 51 +++++
 rtl/decode_stage.sv | 71 +++++++
 tb/tb_decode_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: RV32I opcode constants, instruction type enum and the decode packet
// carried from the decode stage to execute.
package decode_stage_pkg;
   localparam int XLEN = 32;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   typedef enum logic [2:0] {IT_NONE, IT_R, IT_I, IT_S, IT_B, IT_U, IT_J} instr_type_e;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      op;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      instr_type_e     itype;
   } decode_pkt_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side valid/ready handshakes of the decode stage;
// slave is the stage itself, master is the surrounding pipeline.
interface decode_stage_if;
   import decode_stage_pkg::*;
   logic            if_valid;
   logic            if_ready;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   logic            id_valid;
   logic            id_ready;
   decode_pkt_t     id_pkt;
   logic            id_illegal;
   modport slave  (input if_valid, if_instr, if_pc, id_ready, output if_ready, id_valid, id_pkt, id_illegal);
   modport master (output if_valid, if_instr, if_pc, id_ready, input if_ready, id_valid, id_pkt, id_illegal);
endinterface

// File: rtl/decode_fields.sv
// decode_fields: combinational instr -> decode packet; the illegal-encoding flag is only
// generated when DECODE_ILLEGAL_CHK_EN is defined, otherwise it is tied low.
module decode_fields
   import decode_stage_pkg::*;
(
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   output decode_pkt_t     pkt,
   output logic            illegal
);
   logic [6:0] op;
   logic [6:0] f7;
   logic [2:0] f3;
   instr_type_e t;
   logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign f7 = instr[31:25];
   assign t = (op == OP_OP) ? IT_R :
              (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? IT_I :
              (op == OP_STORE) ? IT_S :
              (op == OP_BRANCH) ? IT_B :
              (op == OP_LUI || op == OP_AUIPC) ? IT_U :
              (op == OP_JAL) ? IT_J : IT_NONE;
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm = (t == IT_I) ? imm_i :
                (t == IT_S) ? imm_s :
                (t == IT_B) ? imm_b :
                (t == IT_U) ? imm_u :
                (t == IT_J) ? imm_j : '0;
   // signed size cast sign-extends the 32-bit immediate to XLEN
   assign pkt = '{pc: pc, op: op, rd: instr[11:7], rs1: instr[19:15], rs2: instr[24:20],
                  funct3: f3, funct7: f7, imm: XLEN'(imm), itype: t};
`ifdef DECODE_ILLEGAL_CHK_EN
   logic f7_alt;
   assign f7_alt = f7 == 7'b0100000;
   assign illegal = t == IT_NONE || instr[1:0] != 2'b11
      || (op == OP_OP && (!(f7 == 7'd0 || f7_alt) || (f7_alt && !(f3 == 3'b000 || f3 == 3'b101))))
      || (op == OP_IMM && ((f3 == 3'b001 && f7 != 7'd0) || (f3 == 3'b101 && !(f7 == 7'd0 || f7_alt))))
      || (op == OP_LOAD && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
      || (op == OP_STORE && f3 >= 3'b011)
      || (op == OP_BRANCH && (f3 == 3'b010 || f3 == 3'b011))
      || (op == OP_JALR && f3 != 3'b000);
`else
   assign illegal = 1'b0;
`endif
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with a 2-entry skid buffer and accepted-instruction
// counter; illegal-encoding flagging is enabled by defining DECODE_ILLEGAL_CHK_EN.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   decode_stage_if.slave    bus,
   output logic [CNT_W-1:0] dec_count_o
);
   typedef enum logic [1:0] {EMPTY, HALF, FULL} state_e;
   state_e state;
   decode_pkt_t dec_pkt, main_pkt, skid_pkt;
   logic dec_ill, main_ill, skid_ill, rdy, xin, xout;
   decode_fields u_fields (.instr(bus.if_instr), .pc(bus.if_pc), .pkt(dec_pkt), .illegal(dec_ill));
   assign xin = bus.if_valid & rdy;
   assign xout = (state != EMPTY) & bus.id_ready;
   assign bus.if_ready = rdy;
   assign bus.id_valid = state != EMPTY;
   assign bus.id_pkt = main_pkt;
   assign bus.id_illegal = main_ill;
   // rdy is written alongside every state change so it always equals (next state != FULL)
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= EMPTY;
         main_pkt <= '0;
         main_ill <= 1'b0;
         skid_pkt <= '0;
         skid_ill <= 1'b0;
         rdy <= 1'b1;
         dec_count_o <= '0;
      end else if (flush_i) begin
         state <= EMPTY;
         rdy <= 1'b1;
      end else begin
         if (xin) dec_count_o <= dec_count_o + CNT_W'(1);
         case (state)
            EMPTY: if (xin) begin
               main_pkt <= dec_pkt;
               main_ill <= dec_ill;
               state <= HALF;
            end
            HALF: begin
               if (xin && xout) begin
                  main_pkt <= dec_pkt;
                  main_ill <= dec_ill;
               end else if (xin) begin
                  skid_pkt <= dec_pkt;
                  skid_ill <= dec_ill;
                  state <= FULL;
                  rdy <= 1'b0;
               end else if (xout) state <= EMPTY;
            end
            FULL: if (xout) begin
               main_pkt <= skid_pkt;
               main_ill <= skid_ill;
               state <= HALF;
               rdy <= 1'b1;
            end
            default: begin
               state <= EMPTY;
               rdy <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a queue-of-packets
// occupancy model and an arithmetic instruction decoder; CNT_W=4 exercises counter wrap.
module tb_decode_stage;
   import decode_stage_pkg::*;
   typedef struct packed {
      decode_pkt_t pkt;
      logic        ill;
   } exp_t;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic flush_i = 1'b0;
   logic [3:0] dec_count;
   int checks = 0;
   int errors = 0;
   exp_t q[$];
   logic [3:0] m_cnt = '0;
   decode_stage_if bus ();
   decode_stage #(.CNT_W(4)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .bus(bus), .dec_count_o(dec_count));
   always #5 clk_i = ~clk_i;

   function automatic exp_t ref_dec(input logic [31:0] ins, input logic [XLEN-1:0] pc);
      exp_t e;
      int s, v;
      logic [6:0] op, f7;
      logic [2:0] f3;
      s = $signed(ins);
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      e = '0;
      v = 0;
      case (op)
         7'b0110011: e.pkt.itype = IT_R;
         7'b0010011, 7'b0000011, 7'b1100111: begin e.pkt.itype = IT_I; v = s >>> 20; end
         7'b0100011: begin e.pkt.itype = IT_S; v = (s >>> 25) * 32 + int'(ins[11:7]); end
         7'b1100011: begin
            e.pkt.itype = IT_B;
            v = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         end
         7'b0110111, 7'b0010111: begin e.pkt.itype = IT_U; v = (s >>> 12) * 4096; end
         7'b1101111: begin
            e.pkt.itype = IT_J;
            v = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         end
         default: e.pkt.itype = IT_NONE;
      endcase
      e.pkt.pc = pc;
      e.pkt.op = op;
      e.pkt.rd = ins[11:7];
      e.pkt.rs1 = ins[19:15];
      e.pkt.rs2 = ins[24:20];
      e.pkt.funct3 = f3;
      e.pkt.funct7 = f7;
      e.pkt.imm = XLEN'(v);
`ifdef DECODE_ILLEGAL_CHK_EN
      e.ill = e.pkt.itype == IT_NONE || ins[1:0] != 2'b11;
      if (op == 7'b0110011) e.ill |= !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      if (op == 7'b0010011) e.ill |= (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      if (op == 7'b0000011) e.ill |= f3 inside {3'd3, 3'd6, 3'd7};
      if (op == 7'b0100011) e.ill |= f3 >= 3'd3;
      if (op == 7'b1100011) e.ill |= f3 inside {3'd2, 3'd3};
      if (op == 7'b1100111) e.ill |= f3 != 3'd0;
`endif
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("valid", 128'(bus.id_valid), 128'(q.size() != 0));
      chk("ready", 128'(bus.if_ready), 128'(q.size() < 2));
      chk("count", 128'(dec_count), 128'(m_cnt));
      if (q.size() != 0) begin
         chk("pkt", 128'(bus.id_pkt), 128'(q[0].pkt));
         chk("illegal", 128'(bus.id_illegal), 128'(q[0].ill));
      end
   endtask

   task automatic step(input logic rst, input logic fl, input logic v, input logic [31:0] ins,
                       input logic [XLEN-1:0] pc, input logic rdy);
      logic in_x, out_x;
      rst_ni = rst;
      flush_i = fl;
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.if_pc = pc;
      bus.id_ready = rdy;
      @(negedge clk_i);
      chk_state();
      in_x = v && q.size() < 2;
      out_x = q.size() != 0 && rdy;
      @(posedge clk_i);
      if (!rst) begin
         q.delete();
         m_cnt = '0;
      end else if (fl) q.delete();
      else begin
         if (out_x) void'(q.pop_front());
         if (in_x) begin
            q.push_back(ref_dec(ins, pc));
            m_cnt++;
         end
      end
      #1;
   endtask

   logic [31:0] imm_ins [4] = '{32'hFE000FA3, 32'hFE000EE3, 32'h800000EF, 32'hFFFFF037};
   logic [31:0] imm_exp [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFF00000, 32'hFFFFF000};
   logic [31:0] ill_ins [3] = '{32'h0000007F, 32'h40001033, 32'h40000033};
`ifdef DECODE_ILLEGAL_CHK_EN
   logic ill_exp [3] = '{1'b1, 1'b1, 1'b0};
`else
   logic ill_exp [3] = '{1'b0, 1'b0, 1'b0};
`endif
   logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

   initial begin
      logic [31:0] ins;
      bus.if_valid = 1'b0;
      bus.if_instr = '0;
      bus.if_pc = '0;
      bus.id_ready = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid", 128'(bus.id_valid), 128'(0));
      chk("rst_ready", 128'(bus.if_ready), 128'(1));
      chk("rst_pkt", 128'(bus.id_pkt), 128'(0));
      chk("rst_ill", 128'(bus.id_illegal), 128'(0));
      chk("rst_cnt", 128'(dec_count), 128'(0));
      step(1, 0, 1, 32'h00500093, 32'h100, 1);
      chk("addi_valid", 128'(bus.id_valid), 128'(1));
      chk("addi_type", 128'(bus.id_pkt.itype), 128'(IT_I));
      chk("addi_rd", 128'(bus.id_pkt.rd), 128'(1));
      chk("addi_imm", 128'(bus.id_pkt.imm), 128'(5));
      chk("addi_pc", 128'(bus.id_pkt.pc), 128'(32'h100));
      chk("addi_cnt", 128'(dec_count), 128'(1));
      for (int i = 0; i < 8; i++) step(1, 0, 1, $urandom, 32'h200 + 32'(4 * i), 1);
      step(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 1, $urandom, 32'h300 + 32'(4 * i), 0);
      chk("stall_ready", 128'(bus.if_ready), 128'(0));
      chk("stall_cnt", 128'(dec_count), 128'(11));
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
      chk("drained", 128'(bus.id_valid), 128'(0));
      for (int i = 0; i < 2; i++) step(1, 0, 1, $urandom, 32'h400 + 32'(4 * i), 0);
      step(1, 1, 1, $urandom, 32'h408, 0);
      chk("flush_valid", 128'(bus.id_valid), 128'(0));
      chk("flush_ready", 128'(bus.if_ready), 128'(1));
      chk("flush_cnt", 128'(dec_count), 128'(13));
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 1, imm_ins[i], 32'h500 + 32'(4 * i), 1);
         chk("imm", 128'(bus.id_pkt.imm), 128'(imm_exp[i]));
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, ill_ins[i], 32'h600 + 32'(4 * i), 1);
         chk("illegal_dir", 128'(bus.id_illegal), 128'(ill_exp[i]));
      end
      step(1, 0, 1, 32'h0000007F, 32'h700, 1);
      chk("none_type", 128'(bus.id_pkt.itype), 128'(IT_NONE));
      chk("none_imm", 128'(bus.id_pkt.imm), 128'(0));
      for (int i = 0; i < 400; i++) begin
         ins = $urandom;
         if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 1) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
         step(1, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 3; i++) step(1, 0, 1, $urandom, 32'h800 + 32'(4 * i), 0);
      chk("full_ready", 128'(bus.if_ready), 128'(0));
      step(0, 0, 1, $urandom, 32'h900, 0);
      chk("rst2_valid", 128'(bus.id_valid), 128'(0));
      chk("rst2_ready", 128'(bus.if_ready), 128'(1));
      chk("rst2_pkt", 128'(bus.id_pkt), 128'(0));
      chk("rst2_ill", 128'(bus.id_illegal), 128'(0));
      chk("rst2_cnt", 128'(dec_count), 128'(0));
      for (int i = 0; i < 16; i++) step(1, 0, 1, $urandom, 32'hA00 + 32'(4 * i), 1);
      chk("wrap_cnt", 128'(dec_count), 128'(0));
      step(1, 0, 0, 0, 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
